// File: rtl/sipo_ctrl_pkg.sv
// sipo_ctrl_pkg
//   Shared types and helpers for the receive-side serial-to-parallel sequencer.
//   state_e : frame FSM states (HUNT searches for sync, PAYLOAD deserializes words).
//   clog2   : counter-width helper, never returns less than 1 so 1-entry counters stay legal.
package sipo_ctrl_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// sipo_frame_ctrl_if
//   Valid/ready word hand-off between the frame sequencer and the Hamming decoder.
//   word_data  : completed codeword, first-received bit at [0]
//   word_valid : word_data holds an unconsumed word
//   word_ready : consumer accepts the word when word_valid & word_ready
//   master modport: producer (sequencer); slave modport: consumer (decoder).
interface sipo_frame_ctrl_if #(
  parameter int WORD_W = 7
) ();

  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/sipo_word_buf.sv
// sipo_word_buf
//   Single-entry valid/ready output register for completed codewords.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : a completed word is presented this cycle
//   data_i     : the completed word
//   drop_o     : load_i arrived while the register was full and not being consumed;
//                the held word is kept and the new one is lost
//   bus        : master side of the word hand-off
module sipo_word_buf #(
  parameter int WORD_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              drop_o,
  sipo_frame_ctrl_if.master bus
);

  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              can_load;

  // The register can take a new word when empty or when its word leaves this cycle.
  assign can_load = !valid_q || bus.word_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop_o  = 1'b0;
    if (load_i && can_load) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else begin
      if (valid_q && bus.word_ready) valid_d = 1'b0;
      if (load_i) drop_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.word_data  = data_q;
  assign bus.word_valid = valid_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl
//   Receive-side serial-to-parallel sequencer: hunts the bitstream for SYNC_PAT
//   (MSB first), then deserializes WORDS_PER_FRAME codewords of WORD_W bits
//   (LSB first) and hands each one to a valid/ready output register.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     si, si_valid: serial bit and its qualifier; everything holds when si_valid=0
//     ovf_clr     : clears the sticky overflow flag (a same-cycle drop wins)
//     frame_start : one-cycle pulse the cycle after a sync match
//     locked      : high while in PAYLOAD
//     overflow    : sticky, a completed word was dropped
//     word_if     : master side of the word hand-off
//     resync      : only with SIPO_CTRL_RESYNC_EN defined; forces PAYLOAD back
//                   to HUNT (partial word discarded), clears sync progress in HUNT
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int               WORD_W          = 7,
  parameter int               SYNC_W          = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT       = 8'hA5,
  parameter int               WORDS_PER_FRAME = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              si,
  input  logic              si_valid,
`ifdef SIPO_CTRL_RESYNC_EN
  input  logic              resync,
`endif
  input  logic              ovf_clr,
  output logic              frame_start,
  output logic              locked,
  output logic              overflow,
  sipo_frame_ctrl_if.master word_if
);

  localparam int BCW = clog2(WORD_W);
  localparam int WCW = clog2(WORDS_PER_FRAME);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS_PER_FRAME - 1);

  state_e            state_q, state_d;
  logic [SYNC_W-1:0] sync_sr_q, sync_sr_d;
  logic [WORD_W-1:0] payload_sr_q, payload_sr_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic              frame_start_q, frame_start_d;
  logic              overflow_q, overflow_d;

  logic              resync_w;
  logic [SYNC_W-1:0] hunt_shift;
  logic [WORD_W-1:0] word_new;
  logic              sync_hit, pay_take, word_done, frame_end, drop;

`ifdef SIPO_CTRL_RESYNC_EN
  assign resync_w = resync;
`else
  assign resync_w = 1'b0;
`endif

  assign hunt_shift = {sync_sr_q[SYNC_W-2:0], si};
  assign word_new   = {si, payload_sr_q[WORD_W-1:1]};
  // A resync cycle ignores the si bit in both states.
  assign sync_hit   = (state_q == HUNT) && si_valid && !resync_w && (hunt_shift == SYNC_PAT);
  assign pay_take   = (state_q == PAYLOAD) && si_valid && !resync_w;
  assign word_done  = pay_take && (bit_cnt_q == BIT_LAST);
  assign frame_end  = word_done && (word_cnt_q == WORD_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (sync_hit) state_d = PAYLOAD;
      PAYLOAD: if (resync_w || frame_end) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // FSM outputs
  always_comb begin
    locked      = (state_q == PAYLOAD);
    frame_start = frame_start_q;
    overflow    = overflow_q;
  end

  // Sync detector, deserializer and counters. sync_sr is held at zero outside
  // HUNT, so every entry into HUNT starts with no stale sync progress.
  always_comb begin
    sync_sr_d    = sync_sr_q;
    payload_sr_d = payload_sr_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    if (state_q == HUNT) begin
      if (resync_w) begin
        sync_sr_d = '0;
      end else if (si_valid) begin
        sync_sr_d = sync_hit ? '0 : hunt_shift;
      end
      if (sync_hit) begin
        payload_sr_d = '0;
        bit_cnt_d    = '0;
        word_cnt_d   = '0;
      end
    end else begin
      sync_sr_d = '0;
      if (resync_w) begin
        payload_sr_d = '0;
        bit_cnt_d    = '0;
      end else if (si_valid) begin
        payload_sr_d = word_new;
        bit_cnt_d    = word_done ? '0 : bit_cnt_q + 1'b1;
        if (word_done) word_cnt_d = frame_end ? '0 : word_cnt_q + 1'b1;
      end
    end
  end

  assign frame_start_d = sync_hit;
  assign overflow_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_sr_q     <= '0;
      payload_sr_q  <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      frame_start_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      sync_sr_q     <= sync_sr_d;
      payload_sr_q  <= payload_sr_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      frame_start_q <= frame_start_d;
      overflow_q    <= overflow_d;
    end
  end

  // The completed word is handed over at the edge that samples its last bit.
  sipo_word_buf #(
    .WORD_W (WORD_W)
  ) u_word_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (word_done),
    .data_i (word_new),
    .drop_o (drop),
    .bus    (word_if)
  );

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n, si, si_valid, ovf_clr, resync;
  logic frame_start, locked, overflow;

  sipo_frame_ctrl_if #(.WORD_W(7)) word_if ();

  sipo_frame_ctrl #(
    .WORD_W          (7),
    .SYNC_W          (8),
    .SYNC_PAT        (8'hA5),
    .WORDS_PER_FRAME (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .si          (si),
    .si_valid    (si_valid),
`ifdef SIPO_CTRL_RESYNC_EN
    .resync      (resync),
`endif
    .ovf_clr     (ovf_clr),
    .frame_start (frame_start),
    .locked      (locked),
    .overflow    (overflow),
    .word_if     (word_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int fs_cnt  = 0;
  int lk_cnt  = 0;
  int vl_cnt  = 0;

  always @(negedge clk) begin
    if (frame_start === 1'b1) fs_cnt++;
    if (locked === 1'b1) lk_cnt++;
    if (word_if.word_valid === 1'b1) vl_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    si       = b;
    si_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    si_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_sync();
    logic [7:0] p;
    p = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic send_word(input logic [6:0] w);
    for (int i = 0; i < 7; i++) send_bit(w[i]);
  endtask

  task automatic consume();
    si_valid           = 1'b0;
    word_if.word_ready = 1'b1;
    tick();
    word_if.word_ready = 1'b0;
  endtask

  int fs0, lk0, vl0;
  logic [6:0] w;

  initial begin
    rst_n = 1'b0; si = 1'b0; si_valid = 1'b0; ovf_clr = 1'b0; resync = 1'b0;
    word_if.word_ready = 1'b0;

    // 1: reset
    repeat (3) tick();
    check("rst_valid", word_if.word_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_ovf", overflow, 0);
    check("rst_fs", frame_start, 0);
    rst_n = 1'b1;

    // 2 + 5: sync, word 0x5A, then a sync-like word 0x25 (bits 1010010)
    fs0 = fs_cnt;
    send_sync();
    check("t2_fs_pulse", frame_start, 1);
    check("t2_locked", locked, 1);
    send_bit(1'b0);
    check("t2_fs_fall", frame_start, 0);
    w = 7'h5A;
    for (int i = 1; i < 7; i++) send_bit(w[i]);
    check("t2_valid", word_if.word_valid, 1);
    check("t2_data", word_if.word_data, 7'h5A);
    check("t2_locked_mid", locked, 1);
    consume();
    check("t2_consumed", word_if.word_valid, 0);
    send_word(7'h25);
    check("t5_unlocked", locked, 0);
    check("t5_valid", word_if.word_valid, 1);
    check("t5_data", word_if.word_data, 7'h25);
    check("t5_one_fs", fs_cnt - fs0, 1);
    consume();

    // 3: no consumer, second word dropped; clear on the drop cycle loses to set
    send_sync();
    send_word(7'h11);
    check("t3_valid", word_if.word_valid, 1);
    check("t3_data1", word_if.word_data, 7'h11);
    check("t3_ovf_pre", overflow, 0);
    w = 7'h22;
    for (int i = 0; i < 6; i++) send_bit(w[i]);
    ovf_clr = 1'b1;
    send_bit(w[6]);
    ovf_clr = 1'b0;
    check("t3_data_kept", word_if.word_data, 7'h11);
    check("t3_ovf_set_wins", overflow, 1);
    check("t3_unlocked", locked, 0);
    idle(2);
    check("t3_ovf_sticky", overflow, 1);
    si_valid = 1'b0;
    ovf_clr  = 1'b1;
    tick();
    ovf_clr  = 1'b0;
    check("t3_ovf_clr", overflow, 0);
    consume();
    check("t3_consumed", word_if.word_valid, 0);

    // 4: near-miss pattern 0xA4 then zeros
    lk0 = lk_cnt; vl0 = vl_cnt; fs0 = fs_cnt;
    w = 7'h00;
    begin
      logic [7:0] p;
      p = 8'hA4;
      for (int i = 7; i >= 0; i--) send_bit(p[i]);
    end
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    idle(1);
    check("t4_no_lock", lk_cnt - lk0, 0);
    check("t4_no_valid", vl_cnt - vl0, 0);
    check("t4_no_fs", fs_cnt - fs0, 0);

    // 6: reset mid-word, then a clean frame with a si_valid gap mid-word
    send_sync();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    rst_n    = 1'b0;
    si_valid = 1'b0;
    tick();
    rst_n    = 1'b1;
    check("t6_rst_locked", locked, 0);
    check("t6_rst_valid", word_if.word_valid, 0);
    send_sync();
    w = 7'h7F;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) idle(2);
      send_bit(w[i]);
    end
    check("t6_valid", word_if.word_valid, 1);
    check("t6_data", word_if.word_data, 7'h7F);
    check("t6_ovf", overflow, 0);
    check("t6_locked", locked, 1);

`ifdef SIPO_CTRL_RESYNC_EN
    consume();
    si_valid = 1'b0;
    resync   = 1'b1;
    tick();
    resync   = 1'b0;
    check("t6r_exit", locked, 0);
    send_sync();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    si       = 1'b1;
    si_valid = 1'b1;
    resync   = 1'b1;
    tick();
    resync   = 1'b0;
    check("t6r_unlocked", locked, 0);
    check("t6r_no_word", word_if.word_valid, 0);
    send_sync();
    send_word(7'h7F);
    check("t6r_valid", word_if.word_valid, 1);
    check("t6r_data", word_if.word_data, 7'h7F);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
